// File: rtl/deserializer_dbuf_if.sv
// Sample-in / frame-out handshake bundle for deserializer_dbuf, plus frame-length config and flush.
// The slave modport is the deserializer; master is the surrounding producer/consumer.
interface deserializer_dbuf_if #(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
);
    localparam int LEN_W = $clog2(N_SAMPLES) + 1;

    logic [LEN_W-1:0]               cfg_len;
    logic                           flush;
    logic                           recv_val;
    logic                           recv_rdy;
    logic [BIT_WIDTH-1:0]           recv_msg;
    logic                           send_val;
    logic                           send_rdy;
    logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg;
    logic [LEN_W-1:0]               send_len;

    modport master (
        output cfg_len, flush, recv_val, recv_msg, send_rdy,
        input  recv_rdy, send_val, send_msg, send_len
    );

    modport slave (
        input  cfg_len, flush, recv_val, recv_msg, send_rdy,
        output recv_rdy, send_val, send_msg, send_len
    );
endinterface

// File: rtl/deserializer_dbuf.sv
// Double-buffered sample-to-frame deserializer: a fill bank collects samples while the
// output bank holds the previous frame, with configurable frame length and flush.
module deserializer_dbuf #(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
) (
    input logic                 clk,
    input logic                 reset,
    deserializer_dbuf_if.slave  bus
);
    localparam int LEN_W = $clog2(N_SAMPLES) + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                         state_reg, state_next;
    logic [BIT_WIDTH-1:0]           fill_mem [N_SAMPLES];
    logic [LEN_W-1:0]               count_reg;
    logic [LEN_W-1:0]               len_reg;
    logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg_reg;
    logic [LEN_W-1:0]               send_len_reg;
    logic                           send_val_reg;
    logic                           recv_rdy;

    logic                           recv_fire, send_fire;
    logic [LEN_W-1:0]               eff_cfg, cur_len, frame_len, src_len;
    logic                           normal_done, flush_done, done;
    logic                           handoff, to_hold, hold_exit;
    logic [N_SAMPLES*BIT_WIDTH-1:0] copy_msg;

    assign recv_fire = bus.recv_val && recv_rdy;
    assign send_fire = send_val_reg && bus.send_rdy;

    // Out-of-range lengths select a full frame; the live value only matters for slot 0.
    assign eff_cfg = (bus.cfg_len == '0 || bus.cfg_len > LEN_W'(N_SAMPLES))
                     ? LEN_W'(N_SAMPLES) : bus.cfg_len;
    assign cur_len = (count_reg == '0) ? eff_cfg : len_reg;

    assign frame_len   = count_reg + LEN_W'(recv_fire);
    assign normal_done = recv_fire && (count_reg + LEN_W'(1) == cur_len);
    assign flush_done  = (state_reg == FILL) && bus.flush && (count_reg != '0 || recv_fire);
    assign done        = normal_done || flush_done;
    assign handoff     = done && (!send_val_reg || send_fire);
    assign to_hold     = done && !handoff;
    assign hold_exit   = (state_reg == HOLD) && send_fire;

    // In HOLD the held frame length lives in count_reg.
    assign src_len = (state_reg == HOLD) ? count_reg : frame_len;

    // Copy path merges this cycle's sample and zeroes slots past the frame length.
    for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_slot
        logic [BIT_WIDTH-1:0] slot_val;
        assign slot_val = (recv_fire && count_reg == LEN_W'(gi)) ? bus.recv_msg : fill_mem[gi];
        assign copy_msg[gi*BIT_WIDTH +: BIT_WIDTH] = (LEN_W'(gi) < src_len) ? slot_val : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= FILL;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (to_hold)   state_next = HOLD;
            HOLD:    if (hold_exit) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        recv_rdy = (state_reg == FILL) && !reset;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_SAMPLES; k++) begin
            if (recv_fire && count_reg == LEN_W'(k)) fill_mem[k] <= bus.recv_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= '0;
            len_reg      <= '0;
            send_val_reg <= 1'b0;
            send_msg_reg <= '0;
            send_len_reg <= '0;
        end else begin
            if (recv_fire && count_reg == '0) len_reg <= eff_cfg;

            if (handoff || hold_exit)  count_reg <= '0;
            else if (to_hold)          count_reg <= frame_len;
            else if (recv_fire)        count_reg <= count_reg + LEN_W'(1);

            if (handoff || hold_exit) begin
                send_msg_reg <= copy_msg;
                send_len_reg <= src_len;
                send_val_reg <= 1'b1;
            end else if (send_fire) begin
                send_val_reg <= 1'b0;
            end
        end
    end

    assign bus.recv_rdy = recv_rdy;
    assign bus.send_val = send_val_reg;
    assign bus.send_msg = send_msg_reg;
    assign bus.send_len = send_len_reg;
endmodule

// File: tb/tb_deserializer_dbuf.sv
// Directed bench for deserializer_dbuf: full frames, short frames, back-pressure,
// flush, mid-frame length change and mid-frame reset.
module tb_deserializer_dbuf;
    localparam int N  = 8;
    localparam int BW = 32;
    localparam int LW = $clog2(N) + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    deserializer_dbuf_if #(.N_SAMPLES(N), .BIT_WIDTH(BW)) bus ();

    deserializer_dbuf #(.N_SAMPLES(N), .BIT_WIDTH(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [N*BW-1:0] frame(input int first, input int len);
        logic [N*BW-1:0] f;
        f = '0;
        for (int k = 0; k < len; k++) f[k*BW +: BW] = BW'(first + k);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [N*BW-1:0] obs, input logic [N*BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_frame(input string tag, input int first, input int len);
        chk({tag, "_val"}, bus.send_val, 1);
        chk({tag, "_msg"}, bus.send_msg, frame(first, len));
        chk({tag, "_len"}, bus.send_len, len);
        $display("frame %s: first=%0d len=%0d send_len=%0d", tag, first, len, bus.send_len);
    endtask

    task automatic send_sample(input int v);
        bus.recv_val = 1'b1;
        bus.recv_msg = BW'(v);
        chk("recv_rdy", bus.recv_rdy, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.cfg_len  = '0;
        bus.flush    = 1'b0;
        bus.recv_val = 1'b0;
        bus.recv_msg = '0;
        bus.send_rdy = 1'b1;
        reset        = 1'b1;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        chk("rst_recv_rdy", bus.recv_rdy, 0);
        chk("rst_send_val", bus.send_val, 0);
        chk("rst_send_msg", bus.send_msg, 0);
        chk("rst_send_len", bus.send_len, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_recv_rdy", bus.recv_rdy, 1);
        @(negedge clk);

        // cfg_len=0 means a full 8-sample frame
        bus.cfg_len = LW'(0);
        for (int i = 1; i <= 8; i++) begin
            chk("t1_idle", bus.send_val, 0);
            send_sample(i);
        end
        bus.recv_val = 1'b0;
        chk_frame("t1", 1, 8);
        tick();
        chk("t1_drop", bus.send_val, 0);

        // Back-to-back 3-sample frames with no recv bubble
        bus.cfg_len = LW'(3);
        for (int i = 1; i <= 9; i++) begin
            if (i == 4 || i == 7) chk_frame("t2", i - 3, 3);
            else                  chk("t2_idle", bus.send_val, 0);
            send_sample(i);
        end
        bus.recv_val = 1'b0;
        chk_frame("t2", 7, 3);
        tick();
        chk("t2_drop", bus.send_val, 0);

        // Back-pressure drives the fill side into HOLD
        bus.send_rdy = 1'b0;
        bus.cfg_len  = LW'(4);
        for (int i = 1; i <= 8; i++) send_sample(i);
        bus.recv_val = 1'b0;
        chk("t3_hold_rdy", bus.recv_rdy, 0);
        chk_frame("t3a", 1, 4);
        tick();
        tick();
        chk_frame("t3a_stable", 1, 4);
        chk("t3_hold_rdy2", bus.recv_rdy, 0);
        bus.send_rdy = 1'b1;
        tick();
        chk_frame("t3b", 5, 4);
        chk("t3_rdy_back", bus.recv_rdy, 1);
        tick();
        chk("t3_drop", bus.send_val, 0);

        // Flush of a partial frame, then a lone flush that must do nothing
        bus.cfg_len = LW'(8);
        send_sample(10);
        send_sample(11);
        send_sample(12);
        bus.recv_val = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk_frame("t4_flush", 10, 3);
        tick();
        chk("t4_drop", bus.send_val, 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t4_lone_flush", bus.send_val, 0);
        tick();
        chk("t4_lone_flush2", bus.send_val, 0);

        // Flush together with a transfer includes that sample
        send_sample(30);
        bus.flush = 1'b1;
        send_sample(31);
        bus.flush    = 1'b0;
        bus.recv_val = 1'b0;
        chk_frame("t4_flush_xfer", 30, 2);
        tick();
        chk("t4_drop2", bus.send_val, 0);

        // Length change mid-frame only affects the next frame
        bus.cfg_len = LW'(4);
        send_sample(1);
        send_sample(2);
        bus.cfg_len = LW'(2);
        send_sample(3);
        send_sample(4);
        chk_frame("t5a", 1, 4);
        send_sample(5);
        send_sample(6);
        bus.recv_val = 1'b0;
        chk_frame("t5b", 5, 2);
        tick();
        chk("t5_drop", bus.send_val, 0);

        // Mid-frame reset discards the partial frame
        bus.cfg_len = LW'(8);
        for (int i = 50; i <= 54; i++) send_sample(i);
        bus.recv_val = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rst_rdy", bus.recv_rdy, 0);
        tick();
        chk("t6_rst_rdy2", bus.recv_rdy, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_val", bus.send_val, 0);
        chk("t6_len", bus.send_len, 0);
        @(negedge clk);
        for (int i = 20; i <= 27; i++) begin
            chk("t6_idle", bus.send_val, 0);
            send_sample(i);
        end
        bus.recv_val = 1'b0;
        chk_frame("t6", 20, 8);
        tick();
        chk("t6_drop", bus.send_val, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
